// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU for one 8-bit instruction; SLL/SRL use an iterative shifter
// Ports (all logic on rising i_clk, i_rst synchronous active-high):
//   i_in_valid/o_in_ready    instruction handshake; i_instr [7:4] opcode, [1:0] imm2
//   i_pc, i_a, i_b           PC and operands, sampled only on accept
//   o_out_valid/i_out_ready  result handshake; o_result, o_taken, o_overflow held while stalled
//   o_busy                   iterative shift in progress
//   i_ovf_clr/o_ovf_sticky   sticky overflow flag, present only with ALU_SEQ_OVF_STICKY_EN
module alu_seq #(
    parameter int WIDTH      = 8,
    parameter int SHIFT_STEP = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [7:0]       i_instr,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_taken,
    output logic             o_overflow,
`ifdef ALU_SEQ_OVF_STICKY_EN
    input  logic             i_ovf_clr,
    output logic             o_ovf_sticky,
`endif
    output logic             o_busy
);
    localparam int SW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_result, w_res, w_imm, w_sum, w_addi;
    logic             r_taken, r_ovf, r_left, w_tk, w_ov, w_accept, w_is_shift, w_unused;
    logic [SW-1:0]    r_rem, w_shamt, w_step;
    logic [3:0]       w_op;
    assign w_op       = i_instr[7:4];
    assign w_imm      = {{(WIDTH-2){i_instr[1]}}, i_instr[1:0]};
    assign w_shamt    = i_a[SW-1:0];
    assign w_sum      = i_a + i_b;
    assign w_addi     = i_b + w_imm;
    assign w_is_shift = (w_op == 4'h6) || (w_op == 4'h7);
    assign w_unused   = ^i_instr[3:2];
    assign w_accept   = i_in_valid && o_in_ready;
    // Compared one bit wider so SHIFT_STEP == WIDTH never aliases to zero.
    assign w_step     = ({1'b0, r_rem} > (SW+1)'(SHIFT_STEP)) ? SW'(SHIFT_STEP) : r_rem;
    assign o_in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && i_out_ready);
    assign o_out_valid = (r_state == S_DONE);
    assign o_busy      = (r_state == S_BUSY);
    assign o_result    = r_result;
    assign o_taken     = r_taken;
    assign o_overflow  = r_ovf;
    always_comb begin
        w_res = '0;
        w_tk  = 1'b0;
        w_ov  = 1'b0;
        case (w_op)
            4'h0: w_res = i_a;
            4'h1: begin
                w_res = w_sum;
                w_ov  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            4'h2: w_res = i_a & i_b;
            4'h3: w_res = ~i_a;
            4'h4: w_res = ~(i_a | i_b);
            4'h5: w_res = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            4'h6, 4'h7: w_res = i_b;
            4'h8, 4'h9: begin
                w_res = i_b - i_pc - WIDTH'(1);
                w_tk  = 1'b1;
            end
            4'hA, 4'hB: w_res = w_addi;
            4'hC: w_tk = (i_a == i_b);
            4'hD: w_tk = (i_a != i_b);
            4'hE: begin
                w_res = w_addi;
                w_ov  = (i_b[WIDTH-1] == w_imm[WIDTH-1]) && (w_addi[WIDTH-1] != i_b[WIDTH-1]);
            end
            default: w_res = w_imm;
        endcase
    end
    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = (w_is_shift && w_shamt != '0) ? S_BUSY : S_DONE;
        else if (r_state == S_BUSY)
            w_next = (r_rem == w_step) ? S_DONE : S_BUSY;
        else if (r_state == S_DONE && i_out_ready)
            w_next = S_IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    // Shifts load b and walk it in place; r_result is only exposed once DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= '0;
            r_taken  <= 1'b0;
            r_ovf    <= 1'b0;
            r_rem    <= '0;
            r_left   <= 1'b0;
        end else if (w_accept) begin
            r_result <= w_res;
            r_taken  <= w_tk;
            r_ovf    <= w_ov;
            r_rem    <= w_shamt;
            r_left   <= (w_op == 4'h6);
        end else if (r_state == S_BUSY) begin
            r_result <= r_left ? (r_result << w_step) : (r_result >> w_step);
            r_rem    <= r_rem - w_step;
        end
    end
`ifdef ALU_SEQ_OVF_STICKY_EN
    logic r_ovf_sticky;
    assign o_ovf_sticky = r_ovf_sticky;
    // Setting takes priority over clearing in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                    r_ovf_sticky <= 1'b0;
        else if (o_out_valid && i_out_ready && r_ovf) r_ovf_sticky <= 1'b1;
        else if (i_ovf_clr)                           r_ovf_sticky <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
    logic       clk = 0, rst = 1, in_valid = 0, v2 = 0, out_ready = 1, ovf_clr = 0;
    logic [7:0] instr = 0, pc = 0, a = 0, b = 0;
    logic       in_ready, out_valid, taken, overflow, busy, ovf_sticky;
    logic       in_ready2, out_valid2, taken2, overflow2, busy2, ovf_sticky2;
    logic [7:0] result, result2;
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .SHIFT_STEP(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_instr(instr), .i_pc(pc), .i_a(a), .i_b(b), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_result(result), .o_taken(taken), .o_overflow(overflow),
`ifdef ALU_SEQ_OVF_STICKY_EN
        .i_ovf_clr(ovf_clr), .o_ovf_sticky(ovf_sticky),
`endif
        .o_busy(busy));

    alu_seq #(.WIDTH(8), .SHIFT_STEP(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(v2), .o_in_ready(in_ready2),
        .i_instr(instr), .i_pc(pc), .i_a(a), .i_b(b), .o_out_valid(out_valid2),
        .i_out_ready(out_ready), .o_result(result2), .o_taken(taken2), .o_overflow(overflow2),
`ifdef ALU_SEQ_OVF_STICKY_EN
        .i_ovf_clr(ovf_clr), .o_ovf_sticky(ovf_sticky2),
`endif
        .o_busy(busy2));

    function automatic void model(input logic [3:0] op, input logic [1:0] imm,
                                  input logic [7:0] ai, bi, pci, input int step,
                                  output logic [7:0] res, output logic tk, ov, output int lat);
        int sa = int'($signed(ai));
        int sb = int'($signed(bi));
        int si = imm[1] ? int'(imm) - 4 : int'(imm);
        int sh = int'(ai) % 8;
        int s;
        res = 0; tk = 0; ov = 0; lat = 1;
        case (op)
            4'h0: res = ai;
            4'h1: begin s = sa + sb; res = 8'(s); ov = (s > 127) || (s < -128); end
            4'h2: res = ai & bi;
            4'h3: res = ~ai;
            4'h4: res = ~(ai | bi);
            4'h5: res = (sa < sb) ? 8'd1 : 8'd0;
            4'h6: begin res = 8'(int'(bi) * (2 ** sh)); lat = 1 + (sh + step - 1) / step; end
            4'h7: begin res = 8'(int'(bi) / (2 ** sh)); lat = 1 + (sh + step - 1) / step; end
            4'h8, 4'h9: begin res = 8'(int'(bi) - int'(pci) - 1); tk = 1; end
            4'hA, 4'hB: res = 8'(sb + si);
            4'hC: tk = (ai == bi);
            4'hD: tk = (ai != bi);
            4'hE: begin s = sb + si; res = 8'(s); ov = (s > 127) || (s < -128); end
            default: res = 8'(si);
        endcase
    endfunction

    task automatic send(input logic [3:0] op, input logic [1:0] imm, input logic [7:0] ai, bi, pci);
        instr = {op, 2'($urandom), imm}; a = ai; b = bi; pc = pci; in_valid = 1;
        for (int g = 0; g < 50 && !in_ready; g++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL reset_result got %h want 00", result); end
        n_cmp++; if ({taken, overflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {taken, overflow}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef ALU_SEQ_OVF_STICKY_EN
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_sticky got %b want 0", ovf_sticky); end
`endif
        rst = 0;
    endtask

    typedef struct packed {
        logic [3:0] op; logic [1:0] imm; logic [7:0] a, b, pc, res; logic tk, ov;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        int   n;
        v[0] = '{4'h1, 2'd0, 8'h7F, 8'h01, 8'h00, 8'h80, 1'b0, 1'b1};
        v[1] = '{4'h5, 2'd0, 8'hFF, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0};
        v[2] = '{4'h8, 2'd0, 8'h00, 8'h20, 8'h05, 8'h1A, 1'b1, 1'b0};
        v[3] = '{4'hC, 2'd0, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0};
        v[4] = '{4'hD, 2'd0, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0};
        v[5] = '{4'hF, 2'd2, 8'h00, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b0};
        v[6] = '{4'hE, 2'd1, 8'h00, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1};
        v[7] = '{4'hA, 2'd3, 8'h00, 8'h10, 8'h00, 8'h0F, 1'b0, 1'b0};
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            send(v[i].op, v[i].imm, v[i].a, v[i].b, v[i].pc);
            wait_out(n);
            n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL dir%0d_latency got %0d want 1", i, n); end
            n_cmp++; if (result !== v[i].res) begin n_bad++; $display("FAIL dir%0d_result got %h want %h", i, result, v[i].res); end
            n_cmp++; if ({taken, overflow} !== {v[i].tk, v[i].ov}) begin n_bad++; $display("FAIL dir%0d_flags got %b want %b", i, {taken, overflow}, {v[i].tk, v[i].ov}); end
        end
    endtask

    task automatic test_shift();
        int nb;
        out_ready = 1;
        send(4'h6, 2'd0, 8'h03, 8'h11, 8'h00);
        nb = 0;
        while (busy && nb < 50) begin nb++; @(posedge clk); #1; end
        n_cmp++; if (nb !== 3) begin n_bad++; $display("FAIL sll_busy_cycles got %0d want 3", nb); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sll_out_valid got %b want 1", out_valid); end
        n_cmp++; if (result !== 8'h88) begin n_bad++; $display("FAIL sll_result got %h want 88", result); end
        @(posedge clk); #1;
        instr = 8'h60; a = 8'h03; b = 8'h11; v2 = 1;
        @(posedge clk); #1;
        v2 = 0;
        nb = 0;
        while (busy2 && nb < 50) begin nb++; @(posedge clk); #1; end
        n_cmp++; if (nb !== 2) begin n_bad++; $display("FAIL sll_step2_busy_cycles got %0d want 2", nb); end
        n_cmp++; if (result2 !== 8'h88) begin n_bad++; $display("FAIL sll_step2_result got %h want 88", result2); end
        send(4'h7, 2'd0, 8'h00, 8'hC3, 8'h00);
        wait_out(nb);
        n_cmp++; if (nb !== 1 || result !== 8'hC3) begin n_bad++; $display("FAIL srl_shamt0 got lat %0d res %h want lat 1 res c3", nb, result); end
    endtask

    task automatic test_random();
        logic [3:0] op; logic [1:0] imm; logic [7:0] ai, bi, pci, er; logic et, eo;
        int el, n;
        out_ready = 1;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom); imm = 2'($urandom); ai = 8'($urandom); bi = 8'($urandom); pci = 8'($urandom);
            model(op, imm, ai, bi, pci, 1, er, et, eo, el);
            send(op, imm, ai, bi, pci);
            wait_out(n);
            n_cmp++; if (n !== el) begin n_bad++; $display("FAIL rnd%0d_op%h_latency got %0d want %0d", i, op, n, el); end
            n_cmp++; if (result !== er) begin n_bad++; $display("FAIL rnd%0d_op%h_result got %h want %h", i, op, result, er); end
            n_cmp++; if ({taken, overflow} !== {et, eo}) begin n_bad++; $display("FAIL rnd%0d_op%h_flags got %b want %b", i, op, {taken, overflow}, {et, eo}); end
        end
        for (int i = 0; i < 16; i++) begin
            op = (i % 2 == 0) ? 4'h6 : 4'h7; ai = 8'($urandom); bi = 8'($urandom);
            model(op, 2'd0, ai, bi, 8'h00, 2, er, et, eo, el);
            instr = {op, 4'h0}; a = ai; b = bi; v2 = 1;
            @(posedge clk); #1;
            v2 = 0;
            n = 1;
            while (!out_valid2 && n < 60) begin @(posedge clk); #1; n++; end
            n_cmp++; if (n !== el) begin n_bad++; $display("FAIL step2_rnd%0d_latency got %0d want %0d", i, n, el); end
            n_cmp++; if (result2 !== er) begin n_bad++; $display("FAIL step2_rnd%0d_result got %h want %h", i, result2, er); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [7:0] ai, bi, er, mv; logic et, eo;
        int el, n;
        ai = 8'($urandom); bi = 8'($urandom); mv = 8'($urandom);
        model(4'h1, 2'd0, ai, bi, 8'h00, 1, er, et, eo, el);
        out_ready = 0;
        send(4'h1, 2'd0, ai, bi, 8'h00);
        wait_out(n);
        instr = 8'h00; a = mv; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || result !== er || {taken, overflow} !== {et, eo}) begin
                n_bad++; $display("FAIL stall%0d_hold got v%b res %h fl %b want v1 res %h fl %b", i, out_valid, result, {taken, overflow}, er, {et, eo}); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_in_ready got %b want 0", i, in_ready); end
        end
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1 || result !== mv) begin n_bad++; $display("FAIL stall_release_next got v%b res %h want v1 res %h", out_valid, result, mv); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ai, bi;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            ai = 8'($urandom); bi = 8'($urandom);
            instr = 8'h20; a = ai; b = bi; in_valid = 1;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || result !== (ai & bi)) begin
                n_bad++; $display("FAIL b2b%0d got v%b res %h want v1 res %h", i, out_valid, result, ai & bi); end
        end
        in_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        send(4'h7, 2'd0, 8'h07, 8'($urandom), 8'h00);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        n_cmp++; if ({busy, out_valid, in_ready} !== 3'b001) begin n_bad++; $display("FAIL midrst_state got %b want 001", {busy, out_valid, in_ready}); end
        n_cmp++; if (result !== 8'h00) begin n_bad++; $display("FAIL midrst_result got %h want 00", result); end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_discard got %b want 0", out_valid); end
    endtask

`ifdef ALU_SEQ_OVF_STICKY_EN
    task automatic test_sticky();
        int n;
        out_ready = 1;
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_init got %b want 0", ovf_sticky); end
        send(4'h1, 2'd0, 8'h7F, 8'h01, 8'h00);
        wait_out(n);
        @(posedge clk); #1;
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set got %b want 1", ovf_sticky); end
        send(4'h0, 2'd0, 8'h12, 8'h00, 8'h00);
        wait_out(n);
        @(posedge clk); #1;
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_persist got %b want 1", ovf_sticky); end
        ovf_clr = 1;
        @(posedge clk); #1;
        ovf_clr = 0;
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clr got %b want 0", ovf_sticky); end
        send(4'h1, 2'd0, 8'h80, 8'hFF, 8'h00);
        wait_out(n);
        ovf_clr = 1;
        @(posedge clk); #1;
        ovf_clr = 0;
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set_beats_clr got %b want 1", ovf_sticky); end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_shift();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_SEQ_OVF_STICKY_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
